// File: rtl/rename_unit.sv
// Register rename stage: speculative and retirement RATs plus a circular free list of physical tags.
// One rename and one commit per cycle; flush rolls the speculative view back to the retired view.
module rename_unit #(
  parameter int unsigned NUM_ARCH = 32,
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned PHYS_W   = 6,
  parameter int unsigned FL_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rename_valid,
  input  logic [4:0]        rs1_arch,
  input  logic [4:0]        rs2_arch,
  input  logic [4:0]        rd_arch,
  input  logic              rd_we,
  output logic              rename_ready,
  output logic [PHYS_W-1:0] rs1_phys,
  output logic [PHYS_W-1:0] rs2_phys,
  output logic [PHYS_W-1:0] dest_phys_new,
  output logic [PHYS_W-1:0] dest_phys_old,
  input  logic              commit_valid,
  input  logic              commit_we,
  input  logic [4:0]        commit_rd_arch,
  input  logic [PHYS_W-1:0] commit_phys_new,
  input  logic [PHYS_W-1:0] commit_phys_old,
  input  logic              flush,
  output logic [PHYS_W-1:0] free_count
);

  localparam int unsigned FlIdxW = $clog2(FL_DEPTH);
  localparam int unsigned PtrW   = FlIdxW + 1;

  logic [PHYS_W-1:0] spec_rat_q [NUM_ARCH];
  logic [PHYS_W-1:0] ret_rat_q  [NUM_ARCH];
  logic [PHYS_W-1:0] ret_rat_d  [NUM_ARCH];
  logic [PHYS_W-1:0] fl_q       [FL_DEPTH];

  // Pointers carry an extra wrap bit so full (32 free) and empty (0 free) differ.
  logic [PtrW-1:0] spec_head_q, commit_head_q, tail_q;
  logic [PtrW-1:0] commit_head_d, tail_d;

  logic alloc, fire, commit_en;

  assign alloc     = rd_we && (rd_arch != 5'd0);
  assign commit_en = commit_valid && commit_we && (commit_rd_arch != 5'd0);

  always_comb begin
    rs1_phys      = (rs1_arch == 5'd0) ? '0 : spec_rat_q[rs1_arch];
    rs2_phys      = (rs2_arch == 5'd0) ? '0 : spec_rat_q[rs2_arch];
    dest_phys_old = alloc ? spec_rat_q[rd_arch] : '0;
    dest_phys_new = alloc ? fl_q[spec_head_q[FlIdxW-1:0]] : '0;
    free_count    = PHYS_W'(tail_q - spec_head_q);
    rename_ready  = !flush && (!alloc || (free_count != '0));
    fire          = rename_valid && rename_ready;
  end

  // Retirement view including this cycle's commit; flush copies from here.
  always_comb begin
    ret_rat_d     = ret_rat_q;
    commit_head_d = commit_head_q;
    tail_d        = tail_q;
    if (commit_en) begin
      ret_rat_d[commit_rd_arch] = commit_phys_new;
      commit_head_d             = commit_head_q + PtrW'(1);
      tail_d                    = tail_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_ARCH); i++) begin
        spec_rat_q[i] <= PHYS_W'(i);
        ret_rat_q[i]  <= PHYS_W'(i);
      end
      for (int k = 0; k < int'(FL_DEPTH); k++) begin
        fl_q[k] <= PHYS_W'(NUM_PHYS - FL_DEPTH + k);
      end
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= PtrW'(FL_DEPTH);
    end else begin
      ret_rat_q     <= ret_rat_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      if (commit_en) begin
        fl_q[tail_q[FlIdxW-1:0]] <= commit_phys_old;
      end
      if (flush) begin
        spec_rat_q  <= ret_rat_d;
        spec_head_q <= commit_head_d;
      end else if (fire && alloc) begin
        spec_rat_q[rd_arch] <= dest_phys_new;
        spec_head_q         <= spec_head_q + PtrW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: table of single-cycle vectors plus hand-written
// sequences for exhaustion, flush, commit+flush and asynchronous reset.
module tb_rename_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rename_valid;
  logic [4:0] rs1_arch, rs2_arch, rd_arch;
  logic       rd_we;
  logic       rename_ready;
  logic [5:0] rs1_phys, rs2_phys, dest_phys_new, dest_phys_old;
  logic       commit_valid, commit_we;
  logic [4:0] commit_rd_arch;
  logic [5:0] commit_phys_new, commit_phys_old;
  logic       flush;
  logic [5:0] free_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_unit dut (
    .clk             (clk),
    .rst             (rst),
    .rename_valid    (rename_valid),
    .rs1_arch        (rs1_arch),
    .rs2_arch        (rs2_arch),
    .rd_arch         (rd_arch),
    .rd_we           (rd_we),
    .rename_ready    (rename_ready),
    .rs1_phys        (rs1_phys),
    .rs2_phys        (rs2_phys),
    .dest_phys_new   (dest_phys_new),
    .dest_phys_old   (dest_phys_old),
    .commit_valid    (commit_valid),
    .commit_we       (commit_we),
    .commit_rd_arch  (commit_rd_arch),
    .commit_phys_new (commit_phys_new),
    .commit_phys_old (commit_phys_old),
    .flush           (flush),
    .free_count      (free_count)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
    logic       cv;
    logic [4:0] crd;
    logic [5:0] cnew;
    logic [5:0] cold;
    logic       fl;
    logic       e_rdy;
    logic [5:0] e_rs1;
    logic [5:0] e_rs2;
    logic [5:0] e_new;
    logic [5:0] e_old;
    logic [5:0] e_fc;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input int v, input int rs1, input int rs2, input int rd,
                              input int we, input int cv, input int crd, input int cnew,
                              input int cold, input int fl, input int rdy, input int ers1,
                              input int ers2, input int enew, input int eold, input int efc);
    vec_t r;
    r.v = 1'(v);       r.rs1 = 5'(rs1);     r.rs2 = 5'(rs2);     r.rd = 5'(rd);
    r.we = 1'(we);     r.cv = 1'(cv);       r.crd = 5'(crd);     r.cnew = 6'(cnew);
    r.cold = 6'(cold); r.fl = 1'(fl);       r.e_rdy = 1'(rdy);   r.e_rs1 = 6'(ers1);
    r.e_rs2 = 6'(ers2); r.e_new = 6'(enew); r.e_old = 6'(eold);  r.e_fc = 6'(efc);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v, input int rs1, input int rs2, input int rd, input int we,
                       input int cv, input int crd, input int cnew, input int cold,
                       input int fl);
    rename_valid    = 1'(v);
    rs1_arch        = 5'(rs1);
    rs2_arch        = 5'(rs2);
    rd_arch         = 5'(rd);
    rd_we           = 1'(we);
    commit_valid    = 1'(cv);
    commit_we       = 1'(cv);
    commit_rd_arch  = 5'(crd);
    commit_phys_new = 6'(cnew);
    commit_phys_old = 6'(cold);
    flush           = 1'(fl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Single renaming fire at the next negedge; checks the allocated tag.
  task automatic fire_rd(input string name, input int rd, input int exp_new);
    @(negedge clk);
    drive(1, 0, 0, rd, 1, 0, 0, 0, 0, 0);
    #1;
    check(name, dest_phys_new, exp_new);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //        v rs1 rs2 rd we cv crd cnew cold fl  rdy rs1 rs2 new old fc
    vecs[0]  = mk(0, 5, 0, 0, 0,  0, 0, 0,  0,  0,  1, 5,  0,  0,  0,  32);
    vecs[1]  = mk(1, 0, 0, 3, 1,  0, 0, 0,  0,  0,  1, 0,  0,  32, 3,  32);
    vecs[2]  = mk(1, 3, 3, 3, 1,  0, 0, 0,  0,  0,  1, 32, 32, 33, 32, 31);
    vecs[3]  = mk(0, 3, 0, 0, 1,  0, 0, 0,  0,  0,  1, 33, 0,  0,  0,  30);
    vecs[4]  = mk(1, 0, 0, 0, 1,  0, 0, 0,  0,  0,  1, 0,  0,  0,  0,  30);
    vecs[5]  = mk(1, 7, 3, 7, 0,  0, 0, 0,  0,  0,  1, 7,  33, 0,  0,  30);
    vecs[6]  = mk(0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 0,  0,  0,  0,  30);
    vecs[7]  = mk(1, 4, 0, 4, 1,  0, 0, 0,  0,  0,  1, 4,  0,  34, 4,  30);
    vecs[8]  = mk(0, 4, 0, 0, 0,  1, 3, 32, 3,  0,  1, 34, 0,  0,  0,  29);
    vecs[9]  = mk(0, 0, 0, 0, 0,  1, 3, 33, 32, 0,  1, 0,  0,  0,  0,  30);
    vecs[10] = mk(1, 3, 0, 5, 1,  0, 0, 0,  0,  1,  0, 33, 0,  35, 5,  31);
    vecs[11] = mk(0, 4, 3, 6, 1,  0, 0, 0,  0,  0,  1, 4,  33, 34, 6,  32);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].we, vecs[i].cv,
            vecs[i].crd, vecs[i].cnew, vecs[i].cold, vecs[i].fl);
      #1;
      check($sformatf("vec%0d ready", i), rename_ready, vecs[i].e_rdy);
      check($sformatf("vec%0d rs1", i), rs1_phys, vecs[i].e_rs1);
      check($sformatf("vec%0d rs2", i), rs2_phys, vecs[i].e_rs2);
      check($sformatf("vec%0d new", i), dest_phys_new, vecs[i].e_new);
      check($sformatf("vec%0d old", i), dest_phys_old, vecs[i].e_old);
      check($sformatf("vec%0d free_count", i), free_count, vecs[i].e_fc);
    end

    // Exhaustion and wrap of the speculative head.
    do_reset();
    for (int i = 0; i < 32; i++) fire_rd($sformatf("exh alloc%0d", i), (i % 31) + 1, 32 + i);
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    #1;
    check("exh free_count", free_count, 0);
    check("exh ready empty", rename_ready, 0);
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 1, 1, 32, 5, 0);
    #1;
    check("exh ready commit cycle", rename_ready, 0);
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    #1;
    check("exh ready after commit", rename_ready, 1);
    check("exh wrapped tag", dest_phys_new, 5);
    check("exh free_count one", free_count, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("exh free_count refill used", free_count, 0);

    // Flush after a partial commit.
    do_reset();
    fire_rd("fl alloc rd3", 3, 32);
    fire_rd("fl alloc rd4", 4, 33);
    fire_rd("fl alloc rd5", 5, 34);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 3, 32, 3, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    drive(0, 3, 4, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("fl rs1 x3", rs1_phys, 32);
    check("fl rs2 x4", rs2_phys, 4);
    check("fl free_count", free_count, 32);
    @(negedge clk);
    drive(0, 4, 0, 6, 1, 0, 0, 0, 0, 0);
    #1;
    check("fl rs1 x4", rs1_phys, 4);
    check("fl next alloc", dest_phys_new, 33);

    // Commit and flush in the same cycle.
    do_reset();
    fire_rd("cf alloc rd1", 1, 32);
    fire_rd("cf alloc rd2", 2, 33);
    @(negedge clk);
    drive(1, 0, 0, 3, 1, 1, 1, 32, 1, 1);
    #1;
    check("cf ready in flush", rename_ready, 0);
    @(negedge clk);
    drive(0, 1, 2, 3, 1, 0, 0, 0, 0, 0);
    #1;
    check("cf spec x1", rs1_phys, 32);
    check("cf spec x2", rs2_phys, 2);
    check("cf next alloc", dest_phys_new, 33);
    check("cf free_count", free_count, 32);
    for (int i = 0; i < 32; i++) fire_rd($sformatf("cf drain%0d", i), (i % 31) + 1,
                                         (i < 31) ? 33 + i : 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("cf ret x1", rs1_phys, 32);
    check("cf ret x2", rs2_phys, 2);

    // Asynchronous reset between clock edges.
    do_reset();
    for (int i = 0; i < 10; i++) fire_rd($sformatf("ar alloc%0d", i), i + 1, 32 + i);
    @(negedge clk);
    drive(0, 3, 0, 4, 1, 0, 0, 0, 0, 0);
    #1;
    check("ar pre rs1", rs1_phys, 34);
    check("ar pre free_count", free_count, 22);
    #1;
    rst = 1'b1;
    #1;
    check("ar rs1 identity", rs1_phys, 3);
    check("ar old identity", dest_phys_old, 4);
    check("ar new head", dest_phys_new, 32);
    check("ar free_count", free_count, 32);
    check("ar ready", rename_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Rename stage between decode and the ID/EX register. Maps architectural rs1/rs2/rd to 6-bit physical tags: rs1_phys, rs2_phys, dest_phys_new, plus dest_phys_old for later release.
- Keeps a speculative RAT, a retirement RAT and a circular free list of physical registers.
- Commit releases old tags; flush restores the speculative state from the retirement state.
- Downstream forwarding and the PRF consume the produced tags; physical tag 0 is hardwired to x0.

Parameters:
- NUM_ARCH, 32, architectural register count.
- NUM_PHYS, 64, physical register count.
- PHYS_W, 6, physical tag width (log2 NUM_PHYS).
- FL_DEPTH, 32, free list depth (NUM_PHYS - NUM_ARCH).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- rename_valid  in  1  decode presents an instruction this cycle.
- rs1_arch  in  5  source 1 architectural index.
- rs2_arch  in  5  source 2 architectural index.
- rd_arch  in  5  destination architectural index.
- rd_we  in  1  instruction writes rd.
- rename_ready  out  1  rename can accept this cycle.
- rs1_phys  out  PHYS_W  physical tag for rs1.
- rs2_phys  out  PHYS_W  physical tag for rs2.
- dest_phys_new  out  PHYS_W  newly allocated tag for rd, or 0.
- dest_phys_old  out  PHYS_W  previous mapping of rd, or 0.
- commit_valid  in  1  one instruction retires this cycle.
- commit_we  in  1  retiring instruction wrote rd.
- commit_rd_arch  in  5  retiring rd.
- commit_phys_new  in  PHYS_W  retiring dest_phys_new.
- commit_phys_old  in  PHYS_W  retiring dest_phys_old; released to the free list.
- flush  in  1  squash all uncommitted renames.
- free_count  out  PHYS_W  entries currently free in the speculative view (0..32).

Behaviour:
- **Reset** (async, immediate):
  - Both RATs identity: arch i -> phys i.
  - Free list holds 32..63 in order (entry k = 32+k).
  - spec_head = 0, commit_head = 0, tail = 32. Pointers are 6 bits: 5 index bits plus a wrap bit.
  - free_count = 32, rename_ready = 1.
  - Tag outputs are combinational; with inputs 0 they read 0.
- **alloc** = rd_we && rd_arch != 0. For x0 writes, dest_phys_new = 0 and dest_phys_old = 0, with no allocation and no RAT change.
- **Lookup** (combinational, same cycle):
  - rs1_phys = specRAT[rs1_arch]; rs2_phys = specRAT[rs2_arch].
  - dest_phys_old = specRAT[rd_arch] when alloc.
  - dest_phys_new = FL[spec_head] when alloc.
  - Arch 0 always returns 0.
- **Readiness and fire:**
  - rename_ready = !flush && (!alloc || free_count != 0).
  - fire = rename_valid && rename_ready.
  - On fire with alloc: specRAT[rd_arch] <= dest_phys_new and spec_head++.
  - Width: one rename per cycle, so there are no intra-group dependencies.
- **Commit** (commit_valid && commit_we && commit_rd_arch != 0):
  - retRAT[commit_rd_arch] <= commit_phys_new.
  - FL[tail] <= commit_phys_old; tail++; commit_head++.
  - commit_phys_old == 0 never occurs with commit_we=1 and rd != 0; the verifier flags it.
- **free_count** = tail - spec_head, modulo 64. A tag released by commit becomes allocatable the following cycle; there is no same-cycle bypass.
- **Flush:**
  - specRAT <= retRAT including any same-cycle commit update.
  - spec_head <= commit_head including any same-cycle increment.
  - tail advances for a same-cycle commit.
  - Rename does not fire in a flush cycle.
- **Overflow:** free list cannot overflow, since at most 32 tags are ever unmapped. Tail wrap from 31 to 0 toggles the wrap bit.
- **Commit ordering:** commits arrive in allocation order, so commit_head tracks allocation order exactly.
- **Simultaneous fire and commit:** both update independently; the specRAT write comes from rename only.

Test Plan:
- **Reset identity:** reset, rs1_arch=5, rs2_arch=0 -> rs1_phys=5, rs2_phys=0, free_count=32, rename_ready=1.
- **Rename chain:**
  - Fire rd=3 -> dest_phys_new=32, dest_phys_old=3.
  - Next cycle rs1_arch=3 -> rs1_phys=32.
  - Fire rd=3 again -> new=33, old=32; free_count=30.
- **x0 and no-write:** rd=0 with rd_we=1, and rd=7 with rd_we=0 -> dest_phys_new=0, dest_phys_old=0, free_count unchanged.
- **Exhaustion:**
  - 32 allocating fires -> free_count=0; 33rd alloc gives rename_ready=0.
  - Commit old=5 -> ready stays 0 that cycle, is 1 the next, and the allocated tag is 5.
  - Pointer wrap is observed.
- **Flush:**
  - Rename rd=3,4,5 (tags 32,33,34), commit the first, flush.
  - rs1_arch=3 -> 32; rs1_arch=4 -> 4.
  - Next alloc returns 33; free_count=32.
- **Commit+flush same cycle:**
  - Two renames rd=1,2 (tags 32,33).
  - Commit of rd=1 (new=32, old=1) asserted in the same cycle as flush -> retRAT[1]=32, specRAT[1]=32, specRAT[2]=2.
  - Next alloc returns 33; tag 1 sits at the free list tail.
- **Async reset mid-stream:** rst asserted between clock edges after 10 renames -> outputs reflect identity map and free_count=32 before the next clock edge.
